// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle controller: states, opcodes and datapath selects.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WB   = 4'd6,
    S_MEM_WR   = 4'd7,
    S_ALU_WB   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [1:0] EXT_SIGN  = 2'b00;
  localparam logic [1:0] EXT_ZERO  = 2'b01;
  localparam logic [1:0] EXT_UPPER = 2'b10;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_OR    = 2'b11;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_control_opcode_decode.sv
// Opcode decoder: picks the state following DECODE and the immediate extension mode.
module mc_opcode_decode
  import multicycle_control_pkg::*;
#(
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic [5:0] opcode,
  output state_t     next_state,
  output logic [1:0] ext_mode
);

  // Unknown opcodes fall to TRAP or back to FETCH depending on TRAP_ON_ILLEGAL
  always_comb begin
    next_state = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
    ext_mode   = EXT_SIGN;
    case (opcode)
      OP_RTYPE:     next_state = S_EXEC_R;
      OP_LW, OP_SW: next_state = S_MEM_ADDR;
      OP_BEQ:       next_state = S_BRANCH;
      OP_J:         next_state = S_JUMP;
      OP_ADDI:      next_state = S_EXEC_I;
      OP_ANDI, OP_ORI: begin
        next_state = S_EXEC_I;
        ext_mode   = EXT_ZERO;
      end
      OP_LUI: begin
        next_state = S_EXEC_I;
        ext_mode   = EXT_UPPER;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM: sequences fetch/decode/execute/memory/writeback.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       alu_zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] ext_mode,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic [1:0] pc_source,
  output logic [3:0] state,
  output logic       trap
);

  state_t     state_q, state_d;
  state_t     dec_next;
  logic [1:0] dec_ext;
  logic [5:0] op_q;
  logic [1:0] ext_q;
  logic       unused_funct;

  // funct is interpreted by the ALU control, not by this sequencer
  assign unused_funct = ^funct;

  mc_opcode_decode #(.TRAP_ON_ILLEGAL(TRAP_ON_ILLEGAL)) u_dec (
    .opcode     (opcode),
    .next_state (dec_next),
    .ext_mode   (dec_ext)
  );

  assign state    = state_q;
  assign ext_mode = ext_q;

  // State register; opcode and extender mode are captured only while in DECODE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      op_q    <= OP_RTYPE;
      ext_q   <= EXT_SIGN;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        op_q  <= opcode;
        ext_q <= dec_ext;
      end
    end
  end

  // Next state and state-decoded outputs; reset forces every strobe low at once
  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REG;
    alu_op     = ALU_ADD;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    pc_source  = PCS_ALU;
    trap       = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = SRCB_FOUR;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH2;
        state_d   = dec_next;
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
        state_d   = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        if (op_q == OP_ANDI)     alu_op = ALU_FUNCT;
        else if (op_q == OP_ORI) alu_op = ALU_OR;
        else                     alu_op = ALU_ADD;
        state_d   = S_ALU_WB;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = (op_q == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = S_FETCH;
      end
      S_ALU_WB: begin
        reg_write = 1'b1;
        reg_dst   = (op_q == OP_RTYPE);
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_source = PCS_ALUOUT;
        pc_write  = alu_zero;
        state_d   = S_FETCH;
      end
      S_JUMP: begin
        pc_source = PCS_JUMP;
        pc_write  = 1'b1;
        state_d   = S_FETCH;
      end
      S_TRAP: begin
        trap    = 1'b1;
        state_d = S_TRAP;
      end
      default: state_d = S_FETCH;
    endcase
    if (!rst_n) begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      reg_write = 1'b0;
      trap      = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed scenarios plus random instruction mix.
module tb_multicycle_control;
  import multicycle_control_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode, funct;
  logic       alu_zero, mem_ready;

  logic       mem_req, mem_we, ir_write, pc_write, reg_write, alu_src_a, reg_dst, mem_to_reg, trap;
  logic [1:0] ext_mode, alu_src_b, alu_op, pc_source;
  logic [3:0] state;

  logic       t_mem_req, t_mem_we, t_ir_write, t_pc_write, t_reg_write, t_alu_src_a, t_reg_dst, t_mem_to_reg, t_trap;
  logic [1:0] t_ext_mode, t_alu_src_b, t_alu_op, t_pc_source;
  logic [3:0] t_state;

  int checks = 0;
  int errors = 0;
  logic [1:0] cur_ext;
  bit         ext_known;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .alu_zero(alu_zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .ir_write(ir_write),
    .pc_write(pc_write), .reg_write(reg_write), .ext_mode(ext_mode), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .pc_source(pc_source), .state(state), .trap(trap)
  );

  multicycle_control #(.TRAP_ON_ILLEGAL(1'b0)) dut_nop (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .alu_zero(alu_zero),
    .mem_ready(mem_ready), .mem_req(t_mem_req), .mem_we(t_mem_we), .ir_write(t_ir_write),
    .pc_write(t_pc_write), .reg_write(t_reg_write), .ext_mode(t_ext_mode), .alu_src_a(t_alu_src_a),
    .alu_src_b(t_alu_src_b), .alu_op(t_alu_op), .reg_dst(t_reg_dst), .mem_to_reg(t_mem_to_reg),
    .pc_source(t_pc_source), .state(t_state), .trap(t_trap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {mem_req, mem_we, ir_write, pc_write, reg_write, trap}
  function automatic logic [7:0] ctl_obs();
    return {2'b00, mem_req, mem_we, ir_write, pc_write, reg_write, trap};
  endfunction

  function automatic logic [7:0] ctl_obs_nop();
    return {2'b00, t_mem_req, t_mem_we, t_ir_write, t_pc_write, t_reg_write, t_trap};
  endfunction

  // Immediate extension each opcode requires; unlisted opcodes leave it unconstrained
  function automatic bit ext_for(input logic [5:0] op, output logic [1:0] m);
    m = 2'b00;
    if (op == 6'h0C || op == 6'h0D) begin m = 2'b01; return 1'b1; end
    if (op == 6'h0F) begin m = 2'b10; return 1'b1; end
    if (op == 6'h08 || op == 6'h23 || op == 6'h2B || op == 6'h04) return 1'b1;
    return 1'b0;
  endfunction

  // Build the expected phase list for one instruction, then drive and check it cycle by cycle
  task automatic run_instr(input logic [5:0] op, input logic zero, input int fw, input int mw);
    state_t es[$];
    bit     forced[$];
    logic   rdy[$];
    logic [1:0] new_ext;
    bit     new_known;
    for (int i = 0; i < fw; i++) begin es.push_back(S_FETCH); forced.push_back(1); rdy.push_back(0); end
    es.push_back(S_FETCH); forced.push_back(1); rdy.push_back(1);
    es.push_back(S_DECODE); forced.push_back(0); rdy.push_back(0);
    case (op)
      6'h00: begin es.push_back(S_EXEC_R); es.push_back(S_ALU_WB); end
      6'h08, 6'h0C, 6'h0D, 6'h0F: begin es.push_back(S_EXEC_I); es.push_back(S_ALU_WB); end
      6'h04: es.push_back(S_BRANCH);
      6'h02: es.push_back(S_JUMP);
      6'h23, 6'h2B: begin
        es.push_back(S_MEM_ADDR);
        for (int i = 0; i <= mw; i++) es.push_back(op == 6'h23 ? S_MEM_RD : S_MEM_WR);
        if (op == 6'h23) es.push_back(S_MEM_WB);
      end
      default: ;
    endcase
    while (forced.size() < es.size()) begin forced.push_back(0); rdy.push_back(0); end
    if (op == 6'h23 || op == 6'h2B) begin
      for (int i = 0; i <= mw; i++) begin
        forced[fw + 3 + i] = 1;
        rdy[fw + 3 + i] = (i == mw);
      end
    end
    new_known = ext_for(op, new_ext);
    for (int k = 0; k < es.size(); k++) begin
      logic e_req, e_we, e_ir, e_pcw, e_rw;
      string nm;
      @(negedge clk);
      opcode    = (es[k] == S_DECODE) ? op : 6'($urandom);
      funct     = 6'($urandom);
      mem_ready = forced[k] ? rdy[k] : 1'($urandom);
      alu_zero  = (es[k] == S_BRANCH) ? zero : 1'($urandom);
      #1;
      nm = $sformatf("op%02h.c%0d", op, k);
      check({nm, ".state"}, 8'(state), 8'(es[k]));
      e_req = (es[k] == S_FETCH) || (es[k] == S_MEM_RD) || (es[k] == S_MEM_WR);
      e_we  = (es[k] == S_MEM_WR);
      e_ir  = (es[k] == S_FETCH) && mem_ready;
      e_pcw = ((es[k] == S_FETCH) && mem_ready) || ((es[k] == S_BRANCH) && zero) || (es[k] == S_JUMP);
      e_rw  = (es[k] == S_ALU_WB) || (es[k] == S_MEM_WB);
      check({nm, ".ctl"}, ctl_obs(), {2'b00, e_req, e_we, e_ir, e_pcw, e_rw, 1'b0});
      if (ext_known) check({nm, ".ext"}, 8'(ext_mode), 8'(cur_ext));
      if (e_rw) begin
        check({nm, ".reg_dst"}, 8'(reg_dst), 8'(op == 6'h00));
        check({nm, ".mem_to_reg"}, 8'(mem_to_reg), 8'(es[k] == S_MEM_WB));
      end
      if (e_pcw)
        check({nm, ".pc_source"}, 8'(pc_source),
              (es[k] == S_FETCH) ? 8'd0 : (es[k] == S_BRANCH) ? 8'd1 : 8'd2);
      if (es[k] == S_EXEC_I) begin
        check({nm, ".alu_src_b"}, 8'(alu_src_b), 8'd2);
        check({nm, ".alu_op"}, 8'(alu_op), (op == 6'h0C) ? 8'd2 : (op == 6'h0D) ? 8'd3 : 8'd0);
      end
      if (es[k] == S_EXEC_R) check({nm, ".alu_op"}, 8'(alu_op), 8'd2);
      if (es[k] == S_BRANCH) check({nm, ".alu_op"}, 8'(alu_op), 8'd1);
      if (es[k] == S_MEM_ADDR) check({nm, ".alu_src_b"}, 8'(alu_src_b), 8'd2);
      if (es[k] == S_DECODE) begin
        cur_ext   = new_ext;
        ext_known = new_known;
      end
    end
  endtask

  // Hold reset across a clock edge with mem_ready high, check the quiet outputs, release
  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    mem_ready = 1'b1;
    opcode = 6'($urandom);
    #1;
    check({tag, ".rst_state"}, 8'(state), 8'(S_FETCH));
    check({tag, ".rst_ctl"}, ctl_obs(), 8'd0);
    @(negedge clk);
    #1;
    check({tag, ".rst_hold_state"}, 8'(state), 8'(S_FETCH));
    check({tag, ".rst_hold_ctl"}, ctl_obs(), 8'd0);
    check({tag, ".rst_ext"}, 8'(ext_mode), 8'd0);
    check({tag, ".rst_nop_ctl"}, ctl_obs_nop(), 8'd0);
    mem_ready = 1'b0;
    rst_n = 1'b1;
    #1;
    check({tag, ".release_req"}, 8'(mem_req), 8'd1);
    cur_ext   = 2'b00;
    ext_known = 1'b1;
  endtask

  initial begin
    logic [5:0] legal [9];
    legal = '{6'h00, 6'h08, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h02};
    rst_n = 1'b0; opcode = 6'h00; funct = 6'h00; alu_zero = 1'b0; mem_ready = 1'b0;
    cur_ext = 2'b00; ext_known = 1'b1;

    do_reset("init");

    run_instr(6'h00, 1'b0, 0, 0);
    run_instr(6'h23, 1'b0, 3, 3);
    run_instr(6'h04, 1'b1, 0, 0);
    run_instr(6'h04, 1'b0, 0, 0);
    run_instr(6'h0D, 1'b0, 1, 0);
    run_instr(6'h0F, 1'b0, 0, 0);
    run_instr(6'h08, 1'b0, 2, 0);
    run_instr(6'h0C, 1'b0, 0, 0);
    run_instr(6'h2B, 1'b0, 0, 2);
    run_instr(6'h02, 1'b0, 0, 0);

    for (int n = 0; n < 60; n++)
      run_instr(legal[$urandom_range(8, 0)], 1'($urandom), $urandom_range(3, 0), $urandom_range(3, 0));

    // Illegal opcode: trapping instance sticks in TRAP, the other returns to FETCH
    @(negedge clk); opcode = 6'($urandom); mem_ready = 1'b1; #1;
    check("ill.fetch", 8'(state), 8'(S_FETCH));
    @(negedge clk); opcode = 6'h3F; mem_ready = 1'($urandom); #1;
    check("ill.decode", 8'(state), 8'(S_DECODE));
    check("ill.decode_nop", 8'(t_state), 8'(S_DECODE));
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); opcode = 6'($urandom); mem_ready = (c == 0) ? 1'b0 : 1'($urandom);
      alu_zero = 1'($urandom); #1;
      check($sformatf("ill.trap_state%0d", c), 8'(state), 8'(S_TRAP));
      check($sformatf("ill.trap_ctl%0d", c), ctl_obs(), 8'h01);
      if (c == 0) begin
        check("ill.nop_state", 8'(t_state), 8'(S_FETCH));
        check("ill.nop_ctl", ctl_obs_nop(), 8'h20);
      end
    end

    do_reset("post_trap");
    run_instr(6'h08, 1'b0, 0, 0);

    // Reset during a store wait abandons the write
    @(negedge clk); opcode = 6'($urandom); mem_ready = 1'b1; #1;
    check("swrst.fetch", 8'(state), 8'(S_FETCH));
    @(negedge clk); opcode = 6'h2B; mem_ready = 1'b0; #1;
    check("swrst.decode", 8'(state), 8'(S_DECODE));
    @(negedge clk); opcode = 6'($urandom); #1;
    check("swrst.addr", 8'(state), 8'(S_MEM_ADDR));
    @(negedge clk); #1;
    check("swrst.wait_state", 8'(state), 8'(S_MEM_WR));
    check("swrst.wait_ctl", ctl_obs(), 8'h30);
    #2;
    rst_n = 1'b0;
    #1;
    check("swrst.abort_state", 8'(state), 8'(S_FETCH));
    check("swrst.abort_ctl", ctl_obs(), 8'd0);
    do_reset("post_sw");
    run_instr(6'h00, 1'b0, 0, 0);
    run_instr(6'h2B, 1'b0, 1, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
